hdma_multi_controller: RTL
==========================

// Module: hdma_multi_controller
// PURPOSE
//  Parametrised multi-channel CGB-style VRAM DMA engine. Each channel copies BLOCK_BYTES-byte blocks from
//  the CPU address space to VRAM, in general mode (all blocks back-to-back) or HBlank mode (one block per
//  HBlank). Sits beside the CPU bus mux; busy stalls the CPU while the engine owns the bus.
// PARAMETERS
//  NUM_CH      2   number of channels (1..4); lower index = higher priority
//  BLOCK_BYTES 16  bytes per block, power of two (8..64)
//  VRAM_AW     13  VRAM byte-address width
// PORTS
//  clk          in   1        clock
//  reset        in   1        synchronous, active-high
//  cpu_en       in   1        CPU clock enable; all state advances only when high
//  cgb          in   1        CGB mode; starts ignored when low, rdata=8'hff
//  ch_sel       in   $clog2(NUM_CH) (min 1)  channel addressed by register access
//  reg_select   in   3        1:SRC_HI 2:SRC_LO 3:DST_HI 4:DST_LO 5:CTRL; others unused
//  wdata        in   8        register write data
//  write        in   1        register write strobe (qualified by cpu_en)
//  rdata        out  8        CTRL status of ch_sel when reg_select==5, else 8'hff
//  hblank_start in   1        one-cycle pulse at HBlank entry
//  busy         out  1        engine owns the bus (CPU stall)
//  src_addr     out  16       current source byte address
//  vram_addr    out  VRAM_AW  current VRAM byte address
//  dma_write    out  1        VRAM write strobe
//  active_ch    out  $clog2(NUM_CH) (min 1)  channel currently granted
// BEHAVIOUR
//  - Reset: all channels idle, busy=0, dma_write=0, src_addr=0, vram_addr=0, active_ch=0, addr regs=0.
//  - Addr regs: SRC = {SRC_HI, SRC_LO[7:4]} <<4 (low 4 bits forced 0); DST = {DST_HI[4:0], DST_LO[7:4]} <<4,
//    truncated to VRAM_AW. Writes take effect same cycle; changing them mid-transfer has no effect (latched at start).
//  - CTRL write, channel idle: wdata[6:0]=N-1 blocks; bit7=0 general start, bit7=1 HBlank arm. Latch src/dst/N.
//  - CTRL write bit7=0, channel HBlank-armed: stop; current block (if running) finishes, then channel idle.
//  - CTRL write bit7=1 while armed: ignored. General start while channel active: ignored.
//  - CTRL read: {~active, remaining-1}; idle after completion reads 8'hff; after stop reads {1, remaining-1}.
//  - Per-channel FSM: IDLE -> (general) REQ -> XFER -> REQ ... -> IDLE; (HBlank) ARMED -hblank-> REQ -> XFER -> ARMED|IDLE.
//  - hblank_start sets a per-channel pending flag on every ARMED channel; pending survives while another channel
//    holds the bus; a second hblank_start before service does not queue a second block.
//  - Arbiter: when bus free, grant lowest-index channel in REQ; a granted block is never pre-empted. Grant takes
//    effect next cpu_en cycle; no idle cycle between consecutive blocks of a general transfer.
//  - XFER: 2*BLOCK_BYTES cpu_en cycles per block; even phase = read, odd phase = write; dma_write = cpu_en & busy & odd.
//    src_addr/vram_addr = start + block_index*BLOCK_BYTES + byte_index, wrap mod 2^16 / 2^VRAM_AW.
//  - busy high from first XFER cycle through last write phase; drops the cycle after.
//  - Last block done: remaining wraps to 7'h7f, channel -> IDLE. cgb low blocks new starts only; running transfers finish.
//  - reset mid-transfer: immediate abort, all state to reset values.
// CONFIGURATION
//  - HDMA_DONE_IRQ_EN defined: adds output done_irq[NUM_CH-1:0]; bit n pulses one cpu_en cycle when channel n
//    completes its final block (not on stop). Undefined: port absent, no extra logic.
// TESTING
//  - General, ch0, SRC=0x8000? no: SRC=0xC000 DST=0x0100, CTRL=0x01 -> 32 writes, busy 64 cycles, vram_addr 0x0100..0x011F, rdata 0xFF.
//  - HBlank ch1, CTRL=0x82: 3 hblank pulses -> 16 writes each, status 0x01,0x00 between, 0xFF at end; busy low between.
//  - Stop: HBlank CTRL=0x85, one block, write CTRL=0x00 -> no further transfers, rdata=0x84.
//  - Contention: ch0 general 0x03 and ch1 HBlank armed, hblank during ch0 -> ch1 block runs directly after ch0's 4 blocks.
//  - Wrap: SRC=0xFFF0, DST=0x1FF0, CTRL=0x01 -> second block src 0x0000.., vram 0x0000..
//  - Reset mid-block and cgb=0 start attempt -> busy=0 next cycle, rdata=0xFF, no dma_write; HDMA_DONE_IRQ_EN: one pulse per completion.

Source files
------------

// File: rtl/hdma_multi_controller_if.sv
// Register-access and DMA-side bus bundle for hdma_multi_controller.
// The CPU side drives the register strobe; the engine drives status and the VRAM copy bus.
interface hdma_multi_controller_if #(
    parameter int NUM_CH  = 2,
    parameter int VRAM_AW = 13
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]    ch_sel;
    logic [2:0]         reg_select;
    logic [7:0]         wdata;
    logic               write;
    logic [7:0]         rdata;
    logic               busy;
    logic [15:0]        src_addr;
    logic [VRAM_AW-1:0] vram_addr;
    logic               dma_write;
    logic [CH_W-1:0]    active_ch;

    modport master (
        output ch_sel, reg_select, wdata, write,
        input  rdata, busy, src_addr, vram_addr, dma_write, active_ch
    );

    modport slave (
        input  ch_sel, reg_select, wdata, write,
        output rdata, busy, src_addr, vram_addr, dma_write, active_ch
    );
endinterface

// File: rtl/hdma_multi_controller.sv
// Multi-channel CGB-style HDMA/GDMA engine: per-channel block copy from CPU space to VRAM.
// Optional macro HDMA_DONE_IRQ_EN adds done_irq, a per-channel completion pulse.
module hdma_multi_controller #(
    parameter int NUM_CH      = 2,
    parameter int BLOCK_BYTES = 16,
    parameter int VRAM_AW     = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_en,
    input  logic                 cgb,
    input  logic                 hblank_start,
`ifdef HDMA_DONE_IRQ_EN
    output logic [NUM_CH-1:0]    done_irq,
`endif
    hdma_multi_controller_if.slave bus
);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PH_W    = $clog2(2 * BLOCK_BYTES);
    localparam int PH_LAST = 2 * BLOCK_BYTES - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_REQ,
        ST_XFER
    } ch_state_t;

    logic                wr_en;
    logic                busy_reg, busy_next;
    logic [CH_W-1:0]     owner_reg, owner_next;
    logic [PH_W-1:0]     phase_reg, phase_next;
    logic                last_phase, owner_cont, release_bus, bus_free;
    logic                grant_found;
    logic [CH_W-1:0]     grant_idx;
    logic [NUM_CH-1:0]   grant_vec, req_vec, stop_hit, idle_vec, hblank_mode;
    logic [6:0]          rem_q   [NUM_CH];
    logic [15:0]         cur_src [NUM_CH];
    logic [VRAM_AW-1:0]  cur_dst [NUM_CH];
    logic [PH_W-2:0]     byte_idx;
`ifdef HDMA_DONE_IRQ_EN
    logic [NUM_CH-1:0]   done_vec;
    logic [NUM_CH-1:0]   done_irq_reg;
`endif

    assign wr_en      = cpu_en & bus.write;
    assign last_phase = busy_reg && (phase_reg == PH_W'(PH_LAST));
    // General transfers chain blocks without giving up the bus.
    assign owner_cont  = !hblank_mode[owner_reg] && (rem_q[owner_reg] != 7'd0);
    assign release_bus = last_phase && !owner_cont;
    assign bus_free    = !busy_reg || release_bus;

    always_comb begin
        grant_vec   = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus_free && !grant_found && req_vec[i] && !stop_hit[i]) begin
                grant_found  = 1'b1;
                grant_idx    = CH_W'(i);
                grant_vec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_next  = busy_reg;
        owner_next = owner_reg;
        phase_next = phase_reg;
        if (busy_reg) begin
            phase_next = phase_reg + 1'b1;
        end
        if (release_bus) begin
            busy_next = 1'b0;
        end
        if (grant_found) begin
            busy_next  = 1'b1;
            owner_next = grant_idx;
            phase_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg  <= 1'b0;
            owner_reg <= '0;
            phase_reg <= '0;
        end else if (cpu_en) begin
            busy_reg  <= busy_next;
            owner_reg <= owner_next;
            phase_reg <= phase_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            ch_state_t          state_reg, state_next;
            logic [7:0]         src_hi_reg;
            logic [3:0]         src_lo_reg, dst_lo_reg;
            logic [4:0]         dst_hi_reg;
            logic [6:0]         rem_reg, rem_next;
            logic [15:0]        src_reg, src_next;
            logic [VRAM_AW-1:0] dst_reg, dst_next;
            logic               hblank_reg, hblank_next;
            logic               stop_reg, stop_next;
            logic               sel, ctrl_wr, owned_last;
            logic [15:0]        src_start;
            logic [12:0]        dst_start;

            assign sel        = wr_en && (bus.ch_sel == CH_W'(gi));
            assign ctrl_wr    = sel && (bus.reg_select == 3'd5);
            assign owned_last = last_phase && (owner_reg == CH_W'(gi));
            assign src_start  = {src_hi_reg, src_lo_reg, 4'h0};
            assign dst_start  = {dst_hi_reg, dst_lo_reg, 4'h0};
            // A clear bit 7 only stops channels running in HBlank mode.
            assign stop_hit[gi] = ctrl_wr && !bus.wdata[7] && hblank_reg && (state_reg != ST_IDLE);

            always_ff @(posedge clk) begin
                if (reset) begin
                    src_hi_reg <= '0;
                    src_lo_reg <= '0;
                    dst_hi_reg <= '0;
                    dst_lo_reg <= '0;
                end else if (sel) begin
                    case (bus.reg_select)
                        3'd1:    src_hi_reg <= bus.wdata;
                        3'd2:    src_lo_reg <= bus.wdata[7:4];
                        3'd3:    dst_hi_reg <= bus.wdata[4:0];
                        3'd4:    dst_lo_reg <= bus.wdata[7:4];
                        default: ;
                    endcase
                end
            end

            always_comb begin
                state_next  = state_reg;
                rem_next    = rem_reg;
                src_next    = src_reg;
                dst_next    = dst_reg;
                hblank_next = hblank_reg;
                stop_next   = stop_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (ctrl_wr && cgb) begin
                            state_next  = bus.wdata[7] ? ST_ARMED : ST_REQ;
                            rem_next    = bus.wdata[6:0];
                            src_next    = src_start;
                            dst_next    = VRAM_AW'(dst_start);
                            hblank_next = bus.wdata[7];
                            stop_next   = 1'b0;
                        end
                    end
                    ST_ARMED: begin
                        if (stop_hit[gi]) begin
                            state_next = ST_IDLE;
                        end else if (hblank_start) begin
                            state_next = ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (stop_hit[gi]) begin
                            state_next = ST_IDLE;
                        end else if (grant_vec[gi]) begin
                            state_next = ST_XFER;
                        end
                    end
                    ST_XFER: begin
                        if (stop_hit[gi]) begin
                            stop_next = 1'b1;
                        end
                        if (owned_last) begin
                            rem_next = rem_reg - 7'd1;
                            src_next = src_reg + 16'(BLOCK_BYTES);
                            dst_next = dst_reg + VRAM_AW'(BLOCK_BYTES);
                            if (rem_reg == 7'd0) begin
                                state_next = ST_IDLE;
                            end else if (!hblank_reg) begin
                                state_next = ST_XFER;
                            end else if (stop_reg || stop_hit[gi]) begin
                                state_next = ST_IDLE;
                            end else begin
                                state_next = ST_ARMED;
                            end
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg  <= ST_IDLE;
                    rem_reg    <= 7'h7f;
                    src_reg    <= '0;
                    dst_reg    <= '0;
                    hblank_reg <= 1'b0;
                    stop_reg   <= 1'b0;
                end else if (cpu_en) begin
                    state_reg  <= state_next;
                    rem_reg    <= rem_next;
                    src_reg    <= src_next;
                    dst_reg    <= dst_next;
                    hblank_reg <= hblank_next;
                    stop_reg   <= stop_next;
                end
            end

            assign req_vec[gi]     = (state_reg == ST_REQ);
            assign idle_vec[gi]    = (state_reg == ST_IDLE);
            assign hblank_mode[gi] = hblank_reg;
            assign rem_q[gi]       = rem_reg;
            assign cur_src[gi]     = src_reg;
            assign cur_dst[gi]     = dst_reg;
`ifdef HDMA_DONE_IRQ_EN
            assign done_vec[gi]    = owned_last && (rem_reg == 7'd0);
`endif
        end
    endgenerate

    always_comb begin
        bus.rdata = 8'hff;
        if (cgb && (bus.reg_select == 3'd5) && (int'(bus.ch_sel) < NUM_CH)) begin
            bus.rdata = {idle_vec[bus.ch_sel], rem_q[bus.ch_sel]};
        end
    end

    // Even phases read the source byte, odd phases write it to VRAM.
    assign byte_idx      = phase_reg[PH_W-1:1];
    assign bus.busy      = busy_reg;
    assign bus.active_ch = owner_reg;
    assign bus.dma_write = cpu_en & busy_reg & phase_reg[0];
    assign bus.src_addr  = busy_reg ? (cur_src[owner_reg] + 16'(byte_idx)) : 16'h0000;
    assign bus.vram_addr = busy_reg ? (cur_dst[owner_reg] + VRAM_AW'(byte_idx)) : '0;

`ifdef HDMA_DONE_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            done_irq_reg <= '0;
        end else if (cpu_en) begin
            done_irq_reg <= done_vec;
        end
    end
    assign done_irq = done_irq_reg;
`endif
endmodule
